// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// One range check cycle, then 8 shift/correct cycles; out-of-range input is reported via err.
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  bin_out,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [11:0] bcd_reg;
    logic [7:0]  bin_reg;
    logic [2:0]  cnt;

    logic [19:0] shifted;
    logic [11:0] bcd_sh;
    logic [11:0] bcd_fix;
    logic [7:0]  bin_sh;
    logic [3:0]  dig_h;
    logic [3:0]  dig_t;
    logic [3:0]  dig_o;
    logic        invalid;

    // After a right shift a nibble holding 8+ received a carried-in 10/2 = 5 worth 8; -3 fixes it.
    always_comb begin
        shifted = {bcd_reg, bin_reg} >> 1;
        bcd_sh  = shifted[19:8];
        bin_sh  = shifted[7:0];
        bcd_fix = bcd_sh;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_fix[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        dig_h   = bcd_reg[11:8];
        dig_t   = bcd_reg[7:4];
        dig_o   = bcd_reg[3:0];
        invalid = 1'b0;
        if (dig_h > 4'd9 || dig_t > 4'd9 || dig_o > 4'd9) begin
            invalid = 1'b1;
        end else if (dig_h > 4'd2) begin
            invalid = 1'b1;
        end else if (dig_h == 4'd2 && dig_t > 4'd5) begin
            invalid = 1'b1;
        end else if (dig_h == 4'd2 && dig_t == 4'd5 && dig_o > 4'd5) begin
            invalid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CHECK;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    if (invalid) begin
                        bin_out <= '0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_fix;
                    bin_reg <= bin_sh;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bin_out <= bin_sh;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every in-range value is below 256, so eight halvings must drain the BCD register.
    residual_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SHIFT && cnt == 3'd7) |-> (bcd_fix == 12'h000));

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 3 BCD digits in and 8 bits out.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a conversion, sampled on the rising clk edge.
REQ-006 bcd_in  input  12  digits {hundreds[11:8], tens[7:4], ones[3:0]}, sampled with start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when bin_out/err are updated.
REQ-009 bin_out  output  8  binary result, held until the next done.
REQ-010 err  output  1  result status, held until the next done; 1 means invalid input.

Function
Cycle k means the clock period following rising edge k. start is sampled at edge 0.
REQ-011 The FSM SHALL have four states, IDLE, CHECK, SHIFT and DONE; busy SHALL be 1 exactly in CHECK and SHIFT.
REQ-012 In IDLE or DONE with start=1, the block SHALL capture bcd_in into a 12-bit BCD shift register, clear an 8-bit binary shift register, clear the shift counter, and go to CHECK.
REQ-013 A start while busy=1 SHALL be ignored; bcd_in changes while busy SHALL NOT affect the result.
REQ-014 In CHECK (cycle 0) the input SHALL be flagged invalid if any digit is greater than 9 or the decimal value is greater than 255 (hundreds>2; or hundreds=2 and tens>5; or hundreds=2, tens=5 and ones>5).
REQ-015 For invalid input, the block SHALL go to DONE at edge 1 and load bin_out=8'h00 and err=1 there; done is high in cycle 1.
REQ-016 For valid input, the block SHALL go to SHIFT at edge 1.
REQ-017 In SHIFT, on each edge the block SHALL shift {bcd_reg, bin_reg} right by 1 bit, then subtract 3 from each BCD nibble whose shifted value is 8 or more, in the same cycle.
REQ-018 The block SHALL perform exactly 8 shifts, on edges 2 through 9, counted by a 3-bit counter that wraps from 7 to 0 at the final shift.
REQ-019 At edge 9 the block SHALL load bin_out with bin_reg, clear err to 0, and go to DONE; done is high in cycle 9.
REQ-020 done SHALL be 1 only in the DONE state, for exactly one cycle per accepted start.
REQ-021 DONE SHALL go to IDLE on the next edge unless start=1, in which case REQ-012 applies, allowing back-to-back conversions.
REQ-022 The residual BCD register SHALL be 0 after the 8th shift for every valid input; a nonzero residual is a design error, checked by assertion and not visible at the ports.
REQ-023 All arithmetic SHALL be unsigned, and each nibble correction SHALL stay within 4 bits.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, busy=0, done=0, bin_out=8'h00, err=0, the counter to 0 and both shift registers to 0, independent of clk.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse.
REQ-026 After reset is released, the first start SHALL behave per REQ-012.

Verification
REQ-027 bcd_in=12'h255, start pulse -> busy in cycles 0-8; in cycle 9 done=1, bin_out=8'hFF, err=0.
REQ-028 bcd_in=12'h099 -> bin_out=8'h63 in cycle 9; bcd_in=12'h000 -> bin_out=8'h00; bcd_in=12'h128 -> bin_out=8'h80; all with err=0.
REQ-029 bcd_in=12'h256 and bcd_in=12'h1A3 -> done in cycle 1 with err=1 and bin_out=8'h00; a following valid start clears err to 0.
REQ-030 start re-pulsed in cycle 4 with a different bcd_in -> ignored; the cycle-9 result reflects the original input.
REQ-031 start held high continuously with bcd_in=12'h042 -> done every 10 cycles with bin_out=8'h2A each time.
REQ-032 rst_n pulsed low in cycle 5 -> outputs go to reset values immediately and no done occurs; a fresh start of 12'h200 gives bin_out=8'hC8.
REQ-033 A sweep of all 4096 bcd_in codes SHALL match a reference model: result = 100*hundreds + 10*tens + ones with err=0 when valid, otherwise err=1 at cycle 1.
